// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the MMIO UART.
//   - Register word indices (bus_addr[3:2]) for the 16-byte window.
//   - STATUS register bit positions.
//   - TX and RX state machine encodings.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_TX_BUSY  = 2;
  localparam int unsigned ST_RX_VALID = 3;
  localparam int unsigned ST_RX_OVR   = 4;
  localparam int unsigned ST_TX_OVF   = 5;
  localparam int unsigned ST_RX_FRM   = 6;
  localparam int unsigned ST_IRQ_EN   = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo: synchronous FIFO used as the UART transmit queue.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_push, i_data   write request and data
//   i_pop            read request (ignored when empty)
//   o_data           head entry (valid when not empty)
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries
// A push while full is accepted only when a pop happens in the same cycle.
module mmio_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART slave on the core MMIO bus.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   bus_addr/bus_wr_data          byte address and store data from the core
//   bus_cs/bus_wr/bus_rd          region select, store strobe, load strobe
//   bus_rd_data                   combinational read data (0 when not hit)
//   uart_tx                       serial out, idle high
//   uart_rx                       serial in, asynchronous
//   irq                           only with MMIO_UART_IRQ_EN defined
// Registers (bus_addr[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 DIVISOR.
// Optional feature macro: MMIO_UART_IRQ_EN (irq output, STATUS[9:8] IRQ_EN).
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  input  logic        bus_cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic [31:0] bus_rd_data,
  output logic        uart_tx,
  input  logic        uart_rx
`ifdef MMIO_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic                      w_hit, w_wr;
  logic [1:0]                w_idx;
  logic                      w_push, w_pop, w_fifo_full, w_fifo_empty;
  logic [7:0]                w_fifo_data;
  logic [$clog2(TX_DEPTH):0] w_fifo_count;
  logic [15:0]               r_div;
  logic [1:0]                w_irq_en;
  logic [31:0]               w_status;
  logic [2:0]                w_w1c;
  logic                      w_unused;

  tx_state_t   r_tx_state;
  logic [15:0] r_tx_cnt, r_tx_len;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bit;
  logic        r_tx, w_tx_tick, w_tx_busy;

  rx_state_t   r_rx_state;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [15:0] r_rx_cnt, r_rx_len;
  logic [16:0] w_rx_half;
  logic [7:0]  r_rx_shift, r_rx_byte;
  logic [2:0]  r_rx_bit;
  logic        r_rx_valid, r_rx_ovr, r_tx_ovf, r_rx_frm;
  logic        w_rx_tick, w_rx_stop, w_rx_clr, w_rx_busy_hold, w_rx_load;

  assign w_hit  = bus_cs & (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr   = w_hit & bus_wr;
  assign w_idx  = bus_addr[3:2];
  assign w_push = w_wr & (w_idx == REG_TXDATA);
  assign w_w1c  = (w_wr && w_idx == REG_STATUS) ? bus_wr_data[ST_RX_FRM:ST_RX_OVR] : 3'b000;
  assign w_unused = ^{bus_rd, bus_addr[1:0], bus_wr_data[31:16], w_fifo_count};

  mmio_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txq (
    .clk(clk), .reset(reset), .i_push(w_push), .i_data(bus_wr_data[7:0]),
    .i_pop(w_pop), .o_data(w_fifo_data), .o_full(w_fifo_full),
    .o_empty(w_fifo_empty), .o_count(w_fifo_count)
  );

  // ---------------- TX serializer ----------------
  // Bit length is latched at every bit start so a DIVISOR write never
  // stretches or truncates the bit currently on the line.
  assign w_tx_tick = (r_tx_cnt == r_tx_len);
  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign w_pop     = ~w_fifo_empty &
                     ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_tick));
  assign uart_tx   = r_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_len   <= DEFAULT_DIV;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_pop) begin
          r_tx_state <= TX_START; r_tx <= 1'b0; r_tx_shift <= w_fifo_data;
          r_tx_cnt <= '0; r_tx_len <= r_div;
        end
        TX_START: if (w_tx_tick) begin
          r_tx_state <= TX_DATA; r_tx <= r_tx_shift[0]; r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit <= '0; r_tx_cnt <= '0; r_tx_len <= r_div;
        end else r_tx_cnt <= r_tx_cnt + 16'd1;
        TX_DATA: if (w_tx_tick) begin
          r_tx_cnt <= '0; r_tx_len <= r_div;
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= TX_STOP; r_tx <= 1'b1;
          end else begin
            r_tx <= r_tx_shift[0]; r_tx_shift <= r_tx_shift >> 1; r_tx_bit <= r_tx_bit + 3'd1;
          end
        end else r_tx_cnt <= r_tx_cnt + 16'd1;
        TX_STOP: if (w_tx_tick) begin
          r_tx_cnt <= '0; r_tx_len <= r_div;
          if (w_pop) begin
            r_tx_state <= TX_START; r_tx <= 1'b0; r_tx_shift <= w_fifo_data;
          end else begin
            r_tx_state <= TX_IDLE; r_tx <= 1'b1;
          end
        end else r_tx_cnt <= r_tx_cnt + 16'd1;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  assign w_rx_tick = (r_rx_cnt == r_rx_len);
  assign w_rx_half = ({1'b0, r_rx_len} + 17'd1) >> 1;
  assign w_rx_stop = (r_rx_state == RX_STOP) & w_rx_tick;
  assign w_rx_clr  = w_wr & (w_idx == REG_RXDATA);
  // A clear in the same cycle frees the holding register for the new byte.
  assign w_rx_busy_hold = r_rx_valid & ~w_rx_clr;
  assign w_rx_load = w_rx_stop & r_rx_s2 & ~w_rx_busy_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt <= '0; r_rx_len <= DEFAULT_DIV;
      r_rx_shift <= '0; r_rx_bit <= '0;
    end else begin
      r_rx_s1 <= uart_rx; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev & ~r_rx_s2) begin
          r_rx_state <= RX_START; r_rx_cnt <= '0; r_rx_len <= r_div;
        end
        RX_START: if ({1'b0, r_rx_cnt} == w_rx_half) begin
          // Line high at mid-start means a glitch, not a frame.
          if (r_rx_s2) r_rx_state <= RX_IDLE;
          else begin
            r_rx_state <= RX_DATA; r_rx_cnt <= '0; r_rx_len <= r_div; r_rx_bit <= '0;
          end
        end else r_rx_cnt <= r_rx_cnt + 16'd1;
        RX_DATA: if (w_rx_tick) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_cnt <= '0; r_rx_len <= r_div;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          else r_rx_bit <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt + 16'd1;
        RX_STOP: if (w_rx_tick) begin
          r_rx_state <= RX_IDLE; r_rx_cnt <= '0;
        end else r_rx_cnt <= r_rx_cnt + 16'd1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Register file ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= DEFAULT_DIV;
      r_rx_valid <= 1'b0; r_rx_byte <= '0;
      r_rx_ovr <= 1'b0; r_tx_ovf <= 1'b0; r_rx_frm <= 1'b0;
    end else begin
      if (w_wr && w_idx == REG_DIVISOR) r_div <= bus_wr_data[15:0];
      if (w_rx_load) begin
        r_rx_byte <= r_rx_shift; r_rx_valid <= 1'b1;
      end else if (w_rx_clr) r_rx_valid <= 1'b0;
      // Sticky flags: a set in the same cycle as W1C wins.
      r_rx_ovr <= (r_rx_ovr & ~w_w1c[0]) | (w_rx_stop & r_rx_s2 & w_rx_busy_hold);
      r_tx_ovf <= (r_tx_ovf & ~w_w1c[1]) | (w_push & w_fifo_full & ~w_pop);
      r_rx_frm <= (r_rx_frm & ~w_w1c[2]) | (w_rx_stop & ~r_rx_s2);
    end
  end

`ifdef MMIO_UART_IRQ_EN
  logic [1:0] r_irq_en;
  logic       r_irq;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= '0; r_irq <= 1'b0;
    end else begin
      if (w_wr && w_idx == REG_STATUS) r_irq_en <= bus_wr_data[ST_IRQ_EN+1:ST_IRQ_EN];
      r_irq <= (r_irq_en[0] & r_rx_valid) | (r_irq_en[1] & w_fifo_empty & ~w_tx_busy);
    end
  end
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 2'b00;
`endif

  always_comb begin
    w_status = '0;
    w_status[ST_TX_FULL]  = w_fifo_full;
    w_status[ST_TX_EMPTY] = w_fifo_empty;
    w_status[ST_TX_BUSY]  = w_tx_busy;
    w_status[ST_RX_VALID] = r_rx_valid;
    w_status[ST_RX_OVR]   = r_rx_ovr;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_FRM]   = r_rx_frm;
    w_status[ST_IRQ_EN+1:ST_IRQ_EN] = w_irq_en;
  end

  always_comb begin
    bus_rd_data = '0;
    if (w_hit) begin
      case (w_idx)
        REG_TXDATA:  bus_rd_data = '0;
        REG_RXDATA:  bus_rd_data = {23'b0, r_rx_valid, r_rx_byte};
        REG_STATUS:  bus_rd_data = w_status;
        REG_DIVISOR: bus_rd_data = {16'b0, r_div};
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed self-checking bench for mmio_uart (default build).
module tb_mmio_uart;

  localparam logic [31:0] A_TXD = 32'h1000_0000;
  localparam logic [31:0] A_RXD = 32'h1000_0004;
  localparam logic [31:0] A_ST  = 32'h1000_0008;
  localparam logic [31:0] A_DIV = 32'h1000_000C;

  logic        clk, reset;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic        bus_cs, bus_wr, bus_rd;
  logic        uart_tx, uart_rx;

  int n_asserts = 0;
  int n_fails   = 0;

  mmio_uart #(.BASE_ADDR(32'h1000_0000), .TX_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rd_data(bus_rd_data),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_rd = 1'b0; bus_addr = a; bus_wr_data = d;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wr_data = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = a;
    #1 chk(tag, bus_rd_data, exp);
    bus_cs = 1'b0; bus_rd = 1'b0;
  endtask

  // Serial frame with 4-clock bits (DIVISOR=3), line returned high afterwards.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); uart_rx = f[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk); uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Expected line level t clocks into a frame with p-clock bits.
  function automatic logic exp_tx(input logic [7:0] b, input int t, input int p);
    if (t < 0)     return 1'b1;
    if (t < p)     return 1'b0;
    if (t < 9 * p) return b[(t - p) / p];
    return 1'b1;
  endfunction

  initial begin
    int t;
    reset = 1'b1; uart_rx = 1'b1;
    bus_addr = '0; bus_wr_data = '0; bus_cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset_tx", 32'(uart_tx), 32'd1);
    rd(A_ST,  32'h2,   "reset_status");
    rd(A_DIV, 32'h1B1, "reset_div");
    rd(A_RXD, 32'h0,   "reset_rxdata");
    rd(A_TXD, 32'h0,   "txdata_reads0");

    wr(A_DIV, 32'hABCD_0003);
    rd(A_DIV, 32'h3, "div_upper0");

    // Single frame 0xA5
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = A_TXD; bus_wr_data = 32'hA5;
    for (int j = 0; j < 42; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin bus_wr = 1'b0; bus_rd = 1'b1; bus_addr = A_ST; end
      #1;
      chk("tx_a5_line", 32'(uart_tx), 32'(exp_tx(8'hA5, j - 1, 4)));
      chk("tx_a5_busy", 32'(bus_rd_data[2]), 32'(j >= 1 && j <= 40));
    end
    bus_cs = 1'b0; bus_rd = 1'b0;

    // Burst of five + one overflowing write; frames back-to-back
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = A_TXD; bus_wr_data = 32'h1;
    for (int j = 0; j < 203; j++) begin
      @(posedge clk); #1;
      if (j <= 3) bus_wr_data = 32'(j + 2);
      else if (j == 4) bus_wr_data = 32'h6;
      else if (j == 5) begin bus_cs = 1'b0; bus_wr = 1'b0; end
      else if (j == 6) begin bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = A_ST; end
      else begin bus_cs = 1'b0; bus_rd = 1'b0; end
      #1;
      if (j == 6) chk("burst_status", bus_rd_data, 32'h25);
      t = j - 1;
      chk("burst_line", 32'(uart_tx),
          32'((t < 0 || t >= 200) ? 1'b1 : exp_tx(8'(t / 40 + 1), t % 40, 4)));
    end
    wr(A_ST, 32'h20);
    rd(A_ST, 32'h2, "ovf_w1c");

    // DIVISOR=0: one clock per bit
    wr(A_DIV, 32'h0);
    @(negedge clk);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = A_TXD; bus_wr_data = 32'h5A;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin bus_wr = 1'b0; bus_rd = 1'b1; bus_addr = A_ST; end
      #1;
      chk("div0_line", 32'(uart_tx), 32'(exp_tx(8'h5A, j - 1, 1)));
      chk("div0_busy", 32'(bus_rd_data[2]), 32'(j >= 1 && j <= 10));
    end
    bus_cs = 1'b0; bus_rd = 1'b0;
    wr(A_DIV, 32'h3);

    // RX
    rx_frame(8'h3C, 1'b1);
    rd(A_RXD, 32'h13C, "rx_3c");
    rd(A_ST,  32'hA,   "rx_status");
    rx_frame(8'h55, 1'b1);
    rd(A_ST,  32'h1A,  "rx_ovr_set");
    rd(A_RXD, 32'h13C, "rx_ovr_keep");
    @(negedge clk); bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = A_RXD;
    repeat (5) @(negedge clk);
    chk("rd_hold_noeffect", bus_rd_data, 32'h13C);
    bus_cs = 1'b0; bus_rd = 1'b0;
    wr(A_ST, 32'h10);
    rd(A_ST,  32'hA,   "ovr_w1c");
    wr(A_RXD, 32'h0);
    rd(A_RXD, 32'h03C, "rx_clear");
    rx_frame(8'h81, 1'b0);
    rd(A_ST,  32'h42,  "rx_frm");
    rd(A_RXD, 32'h03C, "rx_frm_discard");
    wr(A_ST, 32'h40);
    rd(A_ST,  32'h2,   "frm_w1c");
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    rd(A_ST,  32'h2,   "glitch_noflags");
    rx_frame(8'hC3, 1'b1);
    rd(A_RXD, 32'h1C3, "rx_after_glitch");

    // Decode
    rd(32'h1000_0010, 32'h0, "oow_rd");
    @(negedge clk); bus_cs = 1'b0; bus_rd = 1'b1; bus_addr = A_ST;
    #1 chk("nocs_rd", bus_rd_data, 32'h0);
    bus_rd = 1'b0;
    wr(32'h1000_0010, 32'h55);
    wr(32'h1000_001C, 32'h7);
    wr(32'h1000_0014, 32'h0);
    rd(A_ST,  32'hA, "oow_wr_status");
    rd(A_DIV, 32'h3, "oow_wr_div");
    rd(32'h1000_000F, 32'h3, "addr_lsb_ignored");

    // Reset in the middle of a data bit
    wr(A_TXD, 32'h00);
    repeat (10) @(negedge clk);
    chk("pre_reset_line", 32'(uart_tx), 32'd0);
    #2 reset = 1'b1;
    #1 chk("async_reset_tx", 32'(uart_tx), 32'd1);
    rd(A_ST,  32'h2,   "reset_mid_status");
    rd(A_DIV, 32'h1B1, "reset_mid_div");
    @(negedge clk); reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
Memory-mapped UART slave on the core's MMIO bus, the block directly downstream of the core's memory stage. It consumes bus_addr / bus_wr_data / bus_cs / bus_wr / bus_rd and drives bus_rd_data, which the core muxes into writeback in the same cycle. It provides a TX FIFO, a TX serializer, a single-entry RX holding register with a deserializer, and a programmable baud divider. Frame format is 8N1, LSB first.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; decode is bus_addr[31:4] == BASE_ADDR[31:4].
TX_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
DEFAULT_DIV, 16'd433, reset value of DIVISOR; bit period = DIVISOR+1 clocks.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
bus_addr  in  32  byte address from core
bus_wr_data  in  32  write data
bus_cs  in  1  MMIO region select
bus_wr  in  1  write strobe, one cycle per store
bus_rd  in  1  read strobe
bus_rd_data  out  32  read data, combinational from bus_addr
uart_tx  out  1  serial out, idle high
uart_rx  in  1  serial in, asynchronous

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk. On reset: uart_tx=1, FIFO empty, rx_valid=0, all sticky flags 0, DIVISOR=DEFAULT_DIV, both FSMs IDLE. bus_rd_data is combinational and reads 0 when not hit.
- hit = bus_cs & window match. Register index = bus_addr[3:2]; bus_addr[1:0] ignored.
- Reads have no side effects. The core asserts bus_rd for any non-store instruction whose ALU result falls in the region. bus_rd_data = hit ? reg : 0, valid in the same cycle (0-cycle latency).
- 0x0 TXDATA:
  - W: pushes wr_data[7:0] at the clock edge.
  - If the FIFO is full, the write is dropped and TX_OVF is set.
  - R: 0.
- 0x4 RXDATA:
  - R: {23'b0, rx_valid, rx_byte}.
  - W (any value): clears rx_valid.
- 0x8 STATUS (R):
  - bit0 tx_full, bit1 tx_empty, bit2 tx_busy (FSM not IDLE), bit3 rx_valid.
  - bit4 RX_OVR, bit5 TX_OVF, bit6 RX_FRM.
  - W: write-1-to-clear on bits 4..6; other bits ignored.
- 0xC DIVISOR:
  - R/W bits[15:0]; upper bits read 0.
  - A write takes effect at the next bit boundary. A bit in flight completes on the old count.
- TX FSM: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
  - The FIFO is popped on the IDLE->START transition, and only if not empty.
  - Each state lasts DIVISOR+1 clocks.
  - From STOP: if the FIFO is non-empty, go directly to START (back-to-back frames, no idle gap).
- Simultaneous push and pop in the same cycle are both honoured. When full, the pop frees the slot, so the push succeeds and TX_OVF is not set.
- RX path: 2-FF synchronizer on uart_rx.
  - IDLE: a falling edge moves to START.
  - START: sample at count (DIVISOR+1)>>1. If high (glitch), return to IDLE with no flags set.
  - DATA: sample 8 bits at mid-bit.
  - STOP: sample mid-bit.
    - stop=0: set RX_FRM and discard the byte.
    - stop=1 and rx_valid already set: set RX_OVR and discard the new byte (old byte kept).
    - Otherwise: load rx_byte and set rx_valid.
  - After STOP, return to IDLE.
- A RXDATA write in the same cycle as a byte completion: the completion wins (rx_valid=1, no overrun).
- Sticky-flag set and W1C in the same cycle: set wins.
- Counters are 16-bit. DIVISOR=0 gives a 1-clock bit period and is legal.

Optional Feature:
MMIO_UART_IRQ_EN.
- Defined: adds output irq (1 bit) and register 0x8 bits[9:8] IRQ_EN (R/W, reset 0; bit8 = rx interrupt, bit9 = tx interrupt).
  - irq = (IRQ_EN[0] & rx_valid) | (IRQ_EN[1] & tx_empty & ~tx_busy), registered, reset 0.
  - W1C behaviour of bits 4..6 is unchanged.
- Undefined: no irq port; bits[9:8] read 0 and writes are ignored.

Decomposition:
- Package mmio_uart_pkg: register offset localparams (TXDATA/RXDATA/STATUS/DIVISOR), STATUS bit-index localparams, tx_state_t and rx_state_t enums.
- One sub-module, mmio_uart_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty and a count output.
- The RX/TX FSMs and the register file stay in mmio_uart.

Test Plan:
- Reset mid-frame: assert reset during a TX data bit -> uart_tx=1 immediately, STATUS reads 0x2, DIVISOR reads 433.
- DIVISOR=3, write TXDATA 0xA5 -> uart_tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks. tx_busy=1 for 40 clks.
- DIVISOR=3, five TXDATA writes on consecutive cycles (0x01..0x05) -> first pops immediately, remaining four fill the FIFO, none dropped. A sixth write while full -> STATUS bit5=1, byte dropped. Frames are back-to-back with no idle gap.
- DIVISOR=3, drive rx frame 0x3C -> RXDATA reads 0x13C. A second frame before the RXDATA write -> RX_OVR=1, RXDATA still 0x13C. Write 0x8 with 0x10 -> bit4 clears.
- Rx frame with stop bit 0 -> RX_FRM=1, rx_valid=0. A 1-clock low glitch on uart_rx -> no flags, RX FSM returns to IDLE.
- Address 0x1000_0010 read/write -> bus_rd_data=0, no state change. A read of RXDATA with bus_rd held -> rx_valid unchanged.
